// File: rtl/arith_unit.sv
// arith_unit: single-cycle unsigned arithmetic unit with registered result.
// Operands are zero-extended to 2*W bits; the result is truncated to 2*W bits.
// Build option: define ARITH_DIV_EN to include the divider (DIV/MOD opcodes).
// Without it, DIV and MOD produce a zero result with dz clear.
module arith_unit #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     opcode,
  output logic [2*W-1:0] outau,
  output logic           out_valid,
  output logic           dz
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_INC = 3'b101,
    OP_DEC = 3'b110,
    OP_ABS = 3'b111
  } op_t;

  localparam logic [2*W-1:0] ONE = {{(2*W-1){1'b0}}, 1'b1};

  op_t            op;
  logic [2*W-1:0] ax;
  logic [2*W-1:0] bx;
  logic [2*W-1:0] res;
  logic           dz_n;

  assign op = op_t'(opcode);
  assign ax = {{W{1'b0}}, a};
  assign bx = {{W{1'b0}}, b};

  // Combinational result and divide-by-zero flag for the current operands
  always_comb begin
    res  = '0;
    dz_n = 1'b0;
    case (op)
      OP_ADD: res = ax + bx;
      OP_SUB: res = ax - bx;
      OP_MUL: res = ax * bx;
`ifdef ARITH_DIV_EN
      OP_DIV: begin
        if (b == '0) begin
          res  = '1;
          dz_n = 1'b1;
        end else begin
          res = {{W{1'b0}}, a / b};
        end
      end
      OP_MOD: begin
        if (b == '0) begin
          res  = ax;
          dz_n = 1'b1;
        end else begin
          res = {{W{1'b0}}, a % b};
        end
      end
`else
      OP_DIV: res = '0;
      OP_MOD: res = '0;
`endif
      OP_INC: res = ax + ONE;
      OP_DEC: res = ax - ONE;
      OP_ABS: res = (ax >= bx) ? (ax - bx) : (bx - ax);
      default: res = '0;
    endcase
  end

  // Output registers: capture on accepted operation, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outau     <= '0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      outau     <= res;
      dz        <= dz_n;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit: scoreboard bench for arith_unit (W=16).
// Expected results are queued at issue time; a negedge monitor pops and compares.
module tb_arith_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  opcode = '0;
  logic [31:0] outau;
  logic        out_valid;
  logic        dz;

  arith_unit #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .outau     (outau),
    .out_valid (out_valid),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic        d;
    int unsigned c;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] hold_o = '0;
  logic        hold_d = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic void model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                                output logic [31:0] r, output logic d);
    longint lx = longint'(x);
    longint ly = longint'(y);
    longint v;
    d = 1'b0;
    case (op)
      3'd0: v = lx + ly;
      3'd1: v = lx - ly;
      3'd2: v = lx * ly;
`ifdef ARITH_DIV_EN
      3'd3: if (ly == 0) begin v = 64'hFFFF_FFFF; d = 1'b1; end else v = lx / ly;
      3'd4: if (ly == 0) begin v = lx; d = 1'b1; end else v = lx % ly;
`else
      3'd3: v = 0;
      3'd4: v = 0;
`endif
      3'd5: v = lx + 1;
      3'd6: v = lx - 1;
      default: v = (lx >= ly) ? lx - ly : ly - lx;
    endcase
    r = v[31:0];
  endfunction

  // Drive one cycle of stimulus; push the given expectation when accepted
  task automatic drive_exp(input logic v, input logic [2:0] op, input logic [15:0] x,
                           input logic [15:0] y, input logic [31:0] eo, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    opcode   = op;
    a        = x;
    b        = y;
    if (v && rst_n) begin
      e.o = eo;
      e.d = ed;
      e.c = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic drive_model(input logic v, input logic [2:0] op, input logic [15:0] x,
                             input logic [15:0] y);
    logic [31:0] r;
    logic        d;
    model(op, x, y, r, d);
    drive_exp(v, op, x, y, r, d);
  endtask

  // Monitor: compare valid/result against the queue, or against held values
  always @(negedge clk) begin
    if (rst_n) begin
      logic want_v;
      while (q.size() > 0 && q[0].c < cyc) void'(q.pop_front());
      want_v = (q.size() > 0) && (q[0].c == cyc);
      check("out_valid", {31'b0, out_valid}, {31'b0, want_v});
      if (want_v) begin
        exp_t e;
        e = q.pop_front();
        check("outau", outau, e.o);
        check("dz", {31'b0, dz}, {31'b0, e.d});
        hold_o = e.o;
        hold_d = e.d;
      end else begin
        check("outau_hold", outau, hold_o);
        check("dz_hold", {31'b0, dz}, {31'b0, hold_d});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("reset_outau", outau, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    check("reset_dz", {31'b0, dz}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    drive_exp(1'b1, 3'd0, 16'h0001, 16'h0010, 32'h0000_0011, 1'b0);
    drive_exp(1'b1, 3'd1, 16'h0001, 16'h0010, 32'hFFFF_FFF1, 1'b0);
    drive_exp(1'b1, 3'd2, 16'h0100, 16'h0110, 32'h0001_1000, 1'b0);
    drive_exp(1'b1, 3'd7, 16'h0100, 16'h0110, 32'h0000_0010, 1'b0);
    drive_exp(1'b1, 3'd2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
    drive_exp(1'b1, 3'd5, 16'hFFFF, 16'h1234, 32'h0001_0000, 1'b0);
    drive_exp(1'b1, 3'd6, 16'h0000, 16'h1234, 32'hFFFF_FFFF, 1'b0);
    drive_exp(1'b1, 3'd7, 16'h0003, 16'h0010, 32'h0000_000D, 1'b0);
`ifdef ARITH_DIV_EN
    drive_exp(1'b1, 3'd3, 16'h00E9, 16'h000F, 32'h0000_000F, 1'b0);
    drive_exp(1'b1, 3'd4, 16'h00E9, 16'h000F, 32'h0000_0008, 1'b0);
    drive_exp(1'b1, 3'd3, 16'h00E9, 16'h0000, 32'hFFFF_FFFF, 1'b1);
    drive_exp(1'b1, 3'd4, 16'h00E9, 16'h0000, 32'h0000_00E9, 1'b1);
`else
    drive_exp(1'b1, 3'd3, 16'h0010, 16'h0002, 32'h0000_0000, 1'b0);
    drive_exp(1'b1, 3'd4, 16'h0010, 16'h0000, 32'h0000_0000, 1'b0);
`endif
    drive_exp(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE, 1'b0);

    // Idle for three cycles: outputs must hold
    repeat (3) drive_model(1'b0, 3'd0, 16'h5555, 16'hAAAA);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [15:0] x;
      logic [15:0] y;
      x = 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      drive_model($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), x, y);
    end

    // Mid-cycle reset with an operation in flight: discarded, outputs clear at once
    drive_model(1'b1, 3'd2, 16'h1234, 16'h5678);
    #2;
    rst_n = 1'b0;
    q.delete();
    hold_o = '0;
    hold_d = 1'b0;
    #1;
    check("async_rst_outau", outau, 32'h0);
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_dz", {31'b0, dz}, 32'h0);
    repeat (2) drive_model(1'b1, 3'd0, 16'h1111, 16'h2222);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;

    // First operations after release
    drive_model(1'b1, 3'd0, 16'h00FF, 16'h0001);
    for (int i = 0; i < 40; i++)
      drive_model($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    drive_model(1'b0, 3'd0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arith_unit.md
ARITH_UNIT -- requirements
Module: arith_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter: W, default 16, operand width; the result width SHALL be 2*W. All values below assume W=16.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands and opcode are sampled when high.
REQ-006 a  input  16  operand A, unsigned.
REQ-007 b  input  16  operand B, unsigned.
REQ-008 opcode  input  3  operation select.
REQ-009 outau  output  32  registered result.
REQ-010 out_valid  output  1  high for exactly one cycle per accepted operation.
REQ-011 dz  output  1  divide-by-zero flag, registered alongside outau.

Function
REQ-012 Each operation SHALL be computed on the 32-bit zero-extensions of a and b, with the result truncated to 32 bits.
REQ-013 Opcode 000 ADD: outau = a + b, including carry into bit 16.
REQ-014 Opcode 001 SUB: outau = a - b modulo 2^32, so a < b gives a wrapped value.
REQ-015 Opcode 010 MUL: outau = a * b, full unsigned 32-bit product.
REQ-016 Opcode 011 DIV: outau = {16'h0, a / b}.
REQ-017 Opcode 100 MOD: outau = {16'h0, a % b}.
REQ-018 Opcode 101 INC: outau = a + 1, so 0xFFFF gives 0x0001_0000.
REQ-019 Opcode 110 DEC: outau = a - 1 modulo 2^32, so 0x0000 gives 0xFFFF_FFFF.
REQ-020 Opcode 111 ABSDIFF: outau = |a - b|.
REQ-021 Divide by zero (b=0):
  - DIV SHALL give outau = 0xFFFF_FFFF and dz = 1.
  - MOD SHALL give outau = {16'h0, a} and dz = 1.
  - Every other case SHALL give dz = 0.
REQ-022 Latency SHALL be 1 cycle: an operation accepted at edge N drives outau, dz and out_valid=1 after edge N.
REQ-023 There SHALL be no backpressure; the block SHALL accept a new operation on every cycle in_valid is high.
REQ-024 When in_valid is low at an edge, out_valid SHALL be 0 and outau and dz SHALL hold their previous values.
REQ-025 The block SHALL have no state machine; the only state is the output registers.

Reset
REQ-026 While rst_n = 0, outau = 0, dz = 0 and out_valid = 0, taking effect immediately without waiting for clk.
REQ-027 An operation accepted in the cycle reset asserts SHALL be discarded.
REQ-028 The first operation after release SHALL be the one sampled at the first rising edge with rst_n = 1 and in_valid = 1.

Configuration
REQ-029 The macro ARITH_DIV_EN SHALL control the divider.
  - Defined: DIV and MOD behave as in REQ-016, REQ-017 and REQ-021.
  - Undefined: no divider logic; opcodes 011 and 100 give outau = 0, dz = 0 and out_valid as normal.

Verification
REQ-030 ADD and SUB: a=0x0001, b=0x0010 -> ADD 0x0000_0011, SUB 0xFFFF_FFF1, each with out_valid one cycle later.
REQ-031 MUL and ABSDIFF: a=0x0100, b=0x0110 -> MUL 0x0001_1000, ABSDIFF 0x0000_0010; a=b=0xFFFF -> MUL 0xFFFE_0001.
REQ-032 DIV and MOD (ARITH_DIV_EN defined): a=0x00E9, b=0x000F -> DIV 0x0000_000F, MOD 0x0000_0008, dz=0.
  - Same with b=0: DIV 0xFFFF_FFFF, MOD 0x0000_00E9, dz=1.
REQ-033 INC/DEC wrap: a=0xFFFF INC -> 0x0001_0000; a=0x0000 DEC -> 0xFFFF_FFFF.
REQ-034 Handshake and reset:
  - in_valid low for 3 cycles -> outau holds, out_valid=0.
  - rst_n pulled low mid-cycle -> outau=0 and out_valid=0 immediately, before the next clk edge.
REQ-035 ARITH_DIV_EN undefined: DIV with a=0x0010, b=0x0002 -> outau=0, dz=0, out_valid=1.
